pool_result_packer: RTL

Receive-side counterpart to the four-channel pooling stage. Accepts per-channel pooled results with per-channel valid strobes and packs the aligned channel values into one word per output pixel. Buffers the words in a small FIFO and presents them downstream on a valid/ready stream, tagging the last pixel of each feature map. Signals completion once the map has fully drained.

---
 rtl/pool_result_packer_pkg.sv | 39 +++
 rtl/pool_result_packer_pack_fifo.sv | 79 +++++++
 rtl/pool_result_packer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pool_result_packer_pkg.sv
// -----------------------------------------------------------------------------
// pool_result_packer_pkg
// Shared definitions for the pooling result packer:
//   - CONV_IN_BIT_WIDTH_F : default per-channel data width (guarded macro)
//   - ST_IDLE/ST_COLLECT/ST_DRAIN : controller state encodings
//   - DEFAULT_FIFO_DEPTH : default word FIFO depth
//   - pix_pos_t plus helpers that walk the (row, col) raster of a square map
// -----------------------------------------------------------------------------
`ifndef CONV_IN_BIT_WIDTH_F
`define CONV_IN_BIT_WIDTH_F 8
`endif

package pool_result_packer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } pix_pos_t;

    // True when pos is the bottom-right pixel of a width x width map.
    function automatic logic is_last_pixel(input pix_pos_t pos, input logic [3:0] width);
        return (pos.col == (width - 4'd1)) && (pos.row == (width - 4'd1));
    endfunction

    // Raster-order successor: col wraps at width-1 and carries into row.
    function automatic pix_pos_t next_pos(input pix_pos_t pos, input logic [3:0] width);
        pix_pos_t nxt;
        nxt.col = (pos.col == (width - 4'd1)) ? 4'd0 : (pos.col + 4'd1);
        nxt.row = (pos.col == (width - 4'd1)) ? (pos.row + 4'd1) : pos.row;
        return nxt;
    endfunction

endpackage

// File: rtl/pool_result_packer_pack_fifo.sv
// -----------------------------------------------------------------------------
// pack_fifo
// Synchronous show-ahead FIFO. The head entry is visible on rdata whenever
// the FIFO is non-empty; rdata reads zero while empty.
// DEPTH must be a power of two, at least 4.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata : write request and data (ignored when full without a pop)
//   pop         : remove the head entry (ignored when empty)
//   rdata       : head entry
//   full, empty : occupancy flags
//   count       : current number of entries
// -----------------------------------------------------------------------------
module pack_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          empty_s;
    logic          full_s;
    logic          do_pop_s;
    logic          do_push_s;

    assign empty_s   = (count_r == {(AW+1){1'b0}});
    assign full_s    = (count_r == FULL_CNT);
    assign do_pop_s  = pop && !empty_s;
    // A pop frees the slot in the same cycle, so push-while-full is legal then.
    assign do_push_s = push && (!full_s || do_pop_s);

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = empty_s ? {DW{1'b0}} : mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/pool_result_packer.sv
// -----------------------------------------------------------------------------
// pool_result_packer
// Collects aligned per-channel pooling results, packs them into one word per
// output pixel (c0 in the low lane), buffers words in pack_fifo and streams
// them out on valid/ready with m_last marking the final pixel of the map.
// Optional build macro: PACK_RELU_EN -- clamp negative enabled lanes to zero.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, pool_o_width,
//   ch_en                 : map start pulse, square map width, channel mask
//   pool_result_valid,
//   pool_result_level1_c* : per-channel strobes and signed results
//   m_data/m_valid/m_ready/m_last : output stream
//   busy, done            : activity level and end-of-map pulse
//   err_overflow/err_align/err_cfg : sticky error flags, cleared by start
// -----------------------------------------------------------------------------
`ifndef CONV_IN_BIT_WIDTH_F
`define CONV_IN_BIT_WIDTH_F 8
`endif

module pool_result_packer
    import pool_result_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int W          = `CONV_IN_BIT_WIDTH_F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          pool_o_width,
    input  logic [3:0]          ch_en,
    input  logic [3:0]          pool_result_valid,
    input  logic signed [W-1:0] pool_result_level1_c0,
    input  logic signed [W-1:0] pool_result_level1_c1,
    input  logic signed [W-1:0] pool_result_level1_c2,
    input  logic signed [W-1:0] pool_result_level1_c3,
    output logic [4*W-1:0]      m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                busy,
    output logic                done,
    output logic                err_overflow,
    output logic                err_align,
    output logic                err_cfg
);
    localparam int DW = 4*W + 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]     state_r;
    logic [3:0]     width_r;
    logic [3:0]     ch_en_r;
    pix_pos_t       pos_r;
    logic           done_r;
    logic           err_overflow_r;
    logic           err_align_r;
    logic           err_cfg_r;

    logic [W-1:0]   lane_in_s [4];
    logic [4*W-1:0] word_s;
    logic [3:0]     masked_vld_s;
    logic           beat_s;
    logic           partial_s;
    logic           last_pix_s;
    logic           pop_s;
    logic           push_s;
    logic           overflow_s;
    logic           drain_done_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [AW:0]    fifo_count_s;
    logic [DW-1:0]  fifo_rdata_s;

    // Disabled lanes read zero; enabled lanes optionally lose negative values.
    function automatic logic [W-1:0] gate_lane(input logic en, input logic [W-1:0] v);
`ifdef PACK_RELU_EN
        return (en && !v[W-1]) ? v : {W{1'b0}};
`else
        return en ? v : {W{1'b0}};
`endif
    endfunction

    assign lane_in_s[0] = pool_result_level1_c0;
    assign lane_in_s[1] = pool_result_level1_c1;
    assign lane_in_s[2] = pool_result_level1_c2;
    assign lane_in_s[3] = pool_result_level1_c3;

    // Packed output word built from the latched channel mask.
    always_comb begin
        word_s = {(4*W){1'b0}};
        for (int i = 0; i < 4; i++) begin
            word_s[i*W +: W] = gate_lane(ch_en_r[i], lane_in_s[i]);
        end
    end

    // Strobes on disabled channels are masked off before alignment checks.
    assign masked_vld_s = pool_result_valid & ch_en_r;
    assign beat_s       = (state_r == ST_COLLECT) && (ch_en_r != 4'd0) &&
                          (masked_vld_s == ch_en_r);
    assign partial_s    = (state_r == ST_COLLECT) && (masked_vld_s != 4'd0) &&
                          (masked_vld_s != ch_en_r);
    assign last_pix_s   = is_last_pixel(pos_r, width_r);
    assign pop_s        = !fifo_empty_s && m_ready;
    assign overflow_s   = beat_s && fifo_full_s && !pop_s;
    assign push_s       = beat_s && !overflow_s;
    // No pushes happen in DRAIN, so the FIFO empties when its last entry pops
    // (or is already empty if the final word was dropped).
    assign drain_done_s = fifo_empty_s ||
                          (pop_s && (fifo_count_s == {{AW{1'b0}}, 1'b1}));

    // Controller: map configuration, pixel position, sticky flags, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            width_r        <= 4'd0;
            ch_en_r        <= 4'd0;
            pos_r          <= 8'd0;
            done_r         <= 1'b0;
            err_overflow_r <= 1'b0;
            err_align_r    <= 1'b0;
            err_cfg_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        err_overflow_r <= 1'b0;
                        err_align_r    <= 1'b0;
                        width_r        <= pool_o_width;
                        ch_en_r        <= ch_en;
                        pos_r          <= 8'd0;
                        if (pool_o_width == 4'd0) begin
                            err_cfg_r <= 1'b1;
                        end else begin
                            err_cfg_r <= 1'b0;
                            state_r   <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    // Position advances even for dropped words to keep m_last aligned.
                    if (beat_s) begin
                        pos_r <= next_pos(pos_r, width_r);
                        if (last_pix_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    if (partial_s) begin
                        err_align_r <= 1'b1;
                    end
                    if (overflow_s) begin
                        err_overflow_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    pack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_pack_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata ({last_pix_s, word_s}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign m_valid      = !fifo_empty_s;
    assign m_data       = fifo_rdata_s[4*W-1:0];
    assign m_last       = fifo_rdata_s[DW-1];
    assign busy         = (state_r != ST_IDLE);
    assign done         = done_r;
    assign err_overflow = err_overflow_r;
    assign err_align    = err_align_r;
    assign err_cfg      = err_cfg_r;

endmodule
